modexp_sequencer: RTL and testbench
===================================

// Module: modexp_sequencer
// PURPOSE
//  Initiator for the modular-multiply handshake: computes base^exponent mod modulus by left-to-right
//  square-and-multiply, issuing one modmul request per step to the modmul controller/datapath and
//  waiting for its done pulse. Sits between the crypto top level and the modmul engine.
// PARAMETERS
//  WIDTH    32     operand/exponent/modulus width in bits
//  TIMEOUT  4096   max cycles waiting for mm_done per request before aborting with error
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  start         in   1      begin a job; sampled only in IDLE
//  base          in   WIDTH  base, captured on accepted start; must be < modulus
//  exponent      in   WIDTH  exponent, captured on accepted start
//  modulus       in   WIDTH  modulus, captured on accepted start
//  busy          out  1      high from accepted start until the cycle result_valid pulses
//  result_valid  out  1      one-cycle pulse: result/error updated
//  result        out  WIDTH  base^exponent mod modulus; held until next result_valid
//  error         out  1      job aborted (bad operands or timeout); held with result
//  mm_start      out  1      drives engine input_data_ready; one-cycle pulse per request
//  mm_a, mm_b    out  WIDTH  multiplicands; stable from mm_start until mm_done accepted
//  mm_n          out  WIDTH  modulus to engine; stable for whole job
//  mm_done       in   1      engine done pulse; honoured only in WAIT states, ignored elsewhere
//  mm_result     in   WIDTH  engine product mod n; valid while mm_done=1
// BEHAVIOUR
//  Reset (async): state IDLE; busy, result_valid, error, mm_start = 0; result, mm_a, mm_b, mm_n = 0.
//   Reset mid-job aborts immediately; no further mm_start; late mm_done ignored.
//  States: IDLE, LOAD, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, NEXT, FINISH.
//  IDLE: start=1 -> capture operands, busy=1, -> LOAD. start while busy ignored.
//  LOAD: modulus==0 or base>=modulus -> error=1, result=0, FINISH (no requests).
//   modulus==1 -> result=0, FINISH. exponent==0 -> result=1, FINISH.
//   else acc=base, bit index i = (MSB index of exponent)-1; i<0 -> FINISH, else -> SQ_REQ.
//   Leading zeros and the top set bit cost no requests.
//  SQ_REQ: mm_start=1 one cycle, mm_a=mm_b=acc -> SQ_WAIT.
//  SQ_WAIT: mm_done -> acc=mm_result; exponent[i] ? MUL_REQ : NEXT.
//  MUL_REQ: mm_start=1 one cycle, mm_a=acc, mm_b=base -> MUL_WAIT.
//  MUL_WAIT: mm_done -> acc=mm_result -> NEXT.
//  NEXT: i==0 -> FINISH, else i=i-1 -> SQ_REQ.
//  FINISH: result=acc (or value set in LOAD), result_valid=1 one cycle, busy=0 -> IDLE.
//  Timeout: cycle counter cleared on entering a WAIT state; reaching TIMEOUT without mm_done ->
//   error=1, result=0, FINISH. mm_done arriving on the same cycle as timeout wins (accepted).
//  Request count = m + p - 1 (m = exponent MSB index, p = popcount). mm_start never asserted twice
//   for one request; mm_a/mm_b/mm_n never change while in a WAIT state.
//  Latency: no-request job -> result_valid 2 cycles after start accepted; each request adds
//   2 cycles + engine response time; each NEXT adds 1 cycle.
//  acc, base, result all WIDTH bits; no arithmetic performed locally besides compares and i decrement.
// STRUCTURE
//  Shared include modexp_defs.vh: state encodings (3-bit localparams), default WIDTH/TIMEOUT.
//  One sub-module: msb_index (combinational priority encoder, WIDTH -> clog2(WIDTH) index + any_set),
//   used in LOAD. Watchdog counter and FSM stay in this module.
// TESTING
//  Engine BFM returns (a*b)%n after programmable delay, checks mm_a/mm_b stability, counts requests.
//  base=3,exp=13,mod=7 -> result=3, error=0, exactly 5 requests (3 SQ, 2 MUL).
//  base=2,exp=10,mod=1000 -> result=24, 4 requests; exp=0,mod=1000 -> result=1, 0 requests, valid at start+2.
//  mod=0 -> error=1,result=0,0 requests; base=9,mod=7 -> error=1; mod=1 -> result=0,error=0.
//  BFM withholds mm_done -> error=1,result=0 exactly TIMEOUT cycles into SQ_WAIT; next job runs cleanly.
//  Assert rst during MUL_WAIT, then a stray mm_done -> all outputs 0, IDLE, no mm_start; start works after.
//  start held high during job and spurious mm_done in IDLE -> ignored; one result_valid per accepted start.

Source files
------------

// File: rtl/modexp_sequencer_pkg.sv
// Shared definitions for the modular-exponentiation sequencer: FSM encoding and default sizing.
package modexp_sequencer_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SQ_REQ   = 3'd2,
        ST_SQ_WAIT  = 3'd3,
        ST_MUL_REQ  = 3'd4,
        ST_MUL_WAIT = 3'd5,
        ST_NEXT     = 3'd6,
        ST_FINISH   = 3'd7
    } state_t;

endpackage

// File: rtl/modexp_sequencer_msb_index.sv
// Combinational priority encoder: position of the highest set bit plus an any-bit-set flag.
module msb_index #(
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic [IDXW-1:0]  index,
    output logic             any_set
);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        index   = '0;
        any_set = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                index   = IDXW'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving an external modmul engine, with a watchdog.
module modexp_sequencer
    import modexp_sequencer_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_result,
    output state_t           dbg_state
);

    localparam int IDXW = $clog2(WIDTH);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    // Engine handshake: mm_start is a one-cycle request with mm_a/mm_b/mm_n already valid and held
    // until the engine answers; the engine answers with a single mm_done pulse carrying mm_result.
    // Only one request is ever outstanding, and mm_done outside a WAIT state is dropped.

    state_t            state;
    logic [WIDTH-1:0]  base_r;
    logic [WIDTH-1:0]  exp_r;
    logic [WIDTH-1:0]  acc;
    logic [IDXW-1:0]   idx;
    logic [CNTW-1:0]   wait_cnt;
    logic              err_r;
    logic [IDXW-1:0]   exp_msb;
    logic              exp_any;
    logic              wait_expired;

    msb_index #(.WIDTH(WIDTH), .IDXW(IDXW)) u_msb_index (
        .value   (exp_r),
        .index   (exp_msb),
        .any_set (exp_any)
    );

    assign wait_expired = (wait_cnt == CNTW'(TIMEOUT - 1));
    assign dbg_state    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            error        <= 1'b0;
            mm_start     <= 1'b0;
            mm_a         <= '0;
            mm_b         <= '0;
            mm_n         <= '0;
            base_r       <= '0;
            exp_r        <= '0;
            acc          <= '0;
            idx          <= '0;
            wait_cnt     <= '0;
            err_r        <= 1'b0;
        end else begin
            mm_start     <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_r <= base;
                        exp_r  <= exponent;
                        mm_n   <= modulus;
                        err_r  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (mm_n == '0 || base_r >= mm_n) begin
                        err_r <= 1'b1;
                        acc   <= '0;
                        state <= ST_FINISH;
                    end else if (mm_n == WIDTH'(1)) begin
                        acc   <= '0;
                        state <= ST_FINISH;
                    end else if (!exp_any) begin
                        acc   <= WIDTH'(1);
                        state <= ST_FINISH;
                    end else begin
                        // The top set bit is consumed by loading acc with base.
                        acc <= base_r;
                        if (exp_msb == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            idx   <= exp_msb - IDXW'(1);
                            state <= ST_SQ_REQ;
                        end
                    end
                end
                ST_SQ_REQ: begin
                    mm_start <= 1'b1;
                    mm_a     <= acc;
                    mm_b     <= acc;
                    wait_cnt <= '0;
                    state    <= ST_SQ_WAIT;
                end
                ST_SQ_WAIT: begin
                    if (mm_done) begin
                        acc   <= mm_result;
                        state <= exp_r[idx] ? ST_MUL_REQ : ST_NEXT;
                    end else if (wait_expired) begin
                        err_r <= 1'b1;
                        acc   <= '0;
                        state <= ST_FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + CNTW'(1);
                    end
                end
                ST_MUL_REQ: begin
                    mm_start <= 1'b1;
                    mm_a     <= acc;
                    mm_b     <= base_r;
                    wait_cnt <= '0;
                    state    <= ST_MUL_WAIT;
                end
                ST_MUL_WAIT: begin
                    if (mm_done) begin
                        acc   <= mm_result;
                        state <= ST_NEXT;
                    end else if (wait_expired) begin
                        err_r <= 1'b1;
                        acc   <= '0;
                        state <= ST_FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + CNTW'(1);
                    end
                end
                ST_NEXT: begin
                    if (idx == '0) begin
                        state <= ST_FINISH;
                    end else begin
                        idx   <= idx - IDXW'(1);
                        state <= ST_SQ_REQ;
                    end
                end
                ST_FINISH: begin
                    result       <= acc;
                    error        <= err_r;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer: engine BFM, arithmetic reference model, result scoreboard.
module tb_modexp_sequencer;
    import modexp_sequencer_pkg::*;

    localparam int W     = 32;
    localparam int TO    = 64;
    localparam int LIMIT = 20000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] base = '0, exponent = '0, modulus = '0;
    logic         busy, result_valid, error, mm_start, mm_done;
    logic [W-1:0] result, mm_a, mm_b, mm_n;
    logic         bfm_done = 1'b0, stray_done = 1'b0;
    logic [W-1:0] bfm_result = '0;
    state_t       dbg_state;

    assign mm_done = bfm_done | stray_done;

    modexp_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
        .modulus(modulus), .busy(busy), .result_valid(result_valid), .result(result),
        .error(error), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
        .mm_done(mm_done), .mm_result(bfm_result), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model(input logic [63:0] b, input logic [63:0] e,
                                  input logic [63:0] n, output logic [63:0] res,
                                  output logic err, output int reqs);
        logic [63:0] r, x, ee;
        int msb;
        err  = 1'b0;
        reqs = 0;
        if (n == 0 || b >= n) begin
            err = 1'b1;
            res = 0;
        end else if (n == 1) begin
            res = 0;
        end else if (e == 0) begin
            res = 1;
        end else begin
            r  = 1;
            x  = b;
            ee = e;
            while (ee != 0) begin
                if (ee[0]) r = (r * x) % n;
                x  = (x * x) % n;
                ee = ee >> 1;
            end
            res = r;
            msb = 0;
            for (int i = 0; i < 64; i++) if (e[i]) msb = i;
            reqs = msb + $countones(e) - 1;
        end
    endfunction

    // ---------------- engine BFM ----------------
    int          bfm_delay   = 0;
    bit          bfm_withhold = 1'b0;
    int          flush_gen   = 0;
    int          req_count   = 0;

    initial begin : bfm
        int          last_flush;
        bit          pending;
        int          countdown;
        logic [63:0] pa, pb, pn;
        last_flush = 0;
        pending    = 1'b0;
        countdown  = 0;
        pa = 0; pb = 0; pn = 0;
        forever begin
            @(negedge clk);
            if (flush_gen != last_flush) begin
                last_flush = flush_gen;
                pending    = 1'b0;
                bfm_done   = 1'b0;
            end
            if (pending) begin
                check("mm_a_stable", mm_a, pa);
                check("mm_b_stable", mm_b, pb);
                check("mm_n_stable", mm_n, pn);
                check("mm_start_once", mm_start, 0);
                if (!bfm_withhold) begin
                    if (countdown == 0) begin
                        bfm_done   = 1'b1;
                        bfm_result = W'((pn == 0) ? 64'd0 : (pa * pb) % pn);
                        pending    = 1'b0;
                    end else begin
                        countdown--;
                    end
                end
            end else begin
                bfm_done = 1'b0;
                if (mm_start) begin
                    req_count++;
                    pa = mm_a; pb = mm_b; pn = mm_n;
                    if (!bfm_withhold && bfm_delay == 0) begin
                        bfm_done   = 1'b1;
                        bfm_result = W'((pn == 0) ? 64'd0 : (pa * pb) % pn);
                    end else begin
                        pending   = 1'b1;
                        countdown = bfm_delay - 1;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_res_q[$];
    logic         exp_err_q[$];
    int           exp_req_q[$];
    int           req_base_q[$];
    int           rd_idx   = 0;
    int           done_cnt = 0;

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst && result_valid) begin
                done_cnt++;
                check("result_valid_expected", (rd_idx < exp_res_q.size()), 1);
                if (rd_idx < exp_res_q.size()) begin
                    check("result", result, exp_res_q[rd_idx]);
                    check("error", error, exp_err_q[rd_idx]);
                    check("request_count", req_count - req_base_q[rd_idx], exp_req_q[rd_idx]);
                    check("busy_low_at_valid", busy, 0);
                    rd_idx++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < LIMIT) begin
            tick(1);
            k++;
        end
        if (busy) check("wait_idle_timeout", busy, 0);
    endtask

    task automatic push_exp(input logic [W-1:0] res, input logic err, input int reqs);
        exp_res_q.push_back(res);
        exp_err_q.push_back(err);
        exp_req_q.push_back(reqs);
        req_base_q.push_back(req_count);
    endtask

    // Launches one job; lat counts cycles from the cycle start was raised to the result_valid cycle,
    // ms_at is the same count at the first mm_start (or -1).
    task automatic run_job(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                           input int delay, input bit hold_start, input bit use_model,
                           output int lat, output int ms_at);
        logic [63:0] res;
        logic        err;
        int          reqs, d0;
        wait_idle();
        bfm_delay = delay;
        if (use_model) begin
            model(b, e, n, res, err, reqs);
            push_exp(W'(res), err, reqs);
        end
        base = b; exponent = e; modulus = n;
        start = 1'b1;
        d0 = done_cnt;
        lat = 0;
        ms_at = -1;
        while (done_cnt == d0 && lat < LIMIT) begin
            tick(1);
            lat++;
            if (!hold_start) start = 1'b0;
            if (mm_start && ms_at < 0) ms_at = lat;
            if (hold_start && done_cnt == d0) check("busy_while_start_held", busy, 1);
        end
        start = 1'b0;
        if (done_cnt == d0) check("job_completes", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [63:0] mres;
        logic        merr;
        int          mreq, lat, ms_at, k;
        logic [W-1:0] rb, re, rn;

        // Model pinned against hand-computed values.
        model(3, 13, 7, mres, merr, mreq);
        check("model_3_13_7_res", mres, 3);
        check("model_3_13_7_reqs", mreq, 5);
        model(2, 10, 1000, mres, merr, mreq);
        check("model_2_10_1000_res", mres, 24);
        check("model_2_10_1000_reqs", mreq, 4);
        model(9, 3, 7, mres, merr, mreq);
        check("model_9_3_7_err", merr, 1);

        tick(3);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_error", error, 0);
        check("rst_mm_start", mm_start, 0);
        check("rst_result", result, 0);
        check("rst_mm_a", mm_a, 0);
        check("rst_mm_b", mm_b, 0);
        check("rst_mm_n", mm_n, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        tick(2);

        // Directed jobs.
        run_job(3, 13, 7, 2, 1'b0, 1'b1, lat, ms_at);
        run_job(2, 10, 1000, 0, 1'b0, 1'b1, lat, ms_at);
        run_job(5, 0, 1000, 1, 1'b0, 1'b1, lat, ms_at);
        check("latency_no_request", lat, 3);
        check("no_request_no_mm_start", ms_at, -1);
        run_job(4, 5, 0, 1, 1'b0, 1'b1, lat, ms_at);
        check("latency_bad_operands", lat, 3);
        run_job(9, 3, 7, 1, 1'b0, 1'b1, lat, ms_at);
        run_job(4, 5, 1, 1, 1'b0, 1'b1, lat, ms_at);
        run_job(6, 1, 11, 1, 1'b0, 1'b1, lat, ms_at);
        run_job(0, 7, 13, 3, 1'b0, 1'b1, lat, ms_at);
        run_job(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 1'b1, lat, ms_at);

        // Engine never answers: watchdog aborts after TO cycles in SQ_WAIT.
        bfm_withhold = 1'b1;
        wait_idle();
        push_exp('0, 1'b1, 1);
        run_job(5, 6, 11, 0, 1'b0, 1'b0, lat, ms_at);
        check("timeout_cycles", lat - ms_at, TO + 1);
        bfm_withhold = 1'b0;
        flush_gen++;
        tick(2);
        run_job(3, 13, 7, 1, 1'b0, 1'b1, lat, ms_at);

        // Reset while a multiply is outstanding, then a stray done.
        wait_idle();
        bfm_delay = 10;
        base = 3; exponent = 13; modulus = 7;
        start = 1'b1;
        k = 0;
        while (dbg_state != ST_MUL_WAIT && k < 2000) begin
            tick(1);
            start = 1'b0;
            k++;
        end
        start = 1'b0;
        check("reached_mul_wait", dbg_state, ST_MUL_WAIT);
        rst = 1'b1;
        flush_gen++;
        tick(2);
        check("midjob_rst_busy", busy, 0);
        check("midjob_rst_mm_start", mm_start, 0);
        check("midjob_rst_mm_a", mm_a, 0);
        check("midjob_rst_mm_n", mm_n, 0);
        check("midjob_rst_result", result, 0);
        check("midjob_rst_error", error, 0);
        check("midjob_rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("post_rst_no_mm_start", mm_start, 0);
            check("post_rst_idle", busy, 0);
        end
        run_job(2, 10, 1000, 2, 1'b0, 1'b1, lat, ms_at);

        // Start held high across a job; spurious done in IDLE.
        run_job(2, 10, 1000, 1, 1'b1, 1'b1, lat, ms_at);
        tick(1);
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        tick(3);
        check("stray_done_idle_busy", busy, 0);
        check("stray_done_idle_state", dbg_state, ST_IDLE);

        // Randomised jobs.
        for (int j = 0; j < 30; j++) begin
            case ($urandom_range(0, 3))
                0:       rn = W'($urandom_range(0, 20));
                1:       rn = W'($urandom_range(2, 65535));
                default: rn = W'($urandom);
            endcase
            rb = W'($urandom);
            if (rn != 0 && $urandom_range(0, 7) != 0) rb = rb % rn;
            re = W'($urandom) >> $urandom_range(0, 31);
            run_job(rb, re, rn, $urandom_range(0, 4), 1'b0, 1'b1, lat, ms_at);
        end

        wait_idle();
        tick(4);
        check("all_results_seen", rd_idx, exp_res_q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
